// File: rtl/bus_dma_host_if.sv
// Register-port and host-bus bundles for bus_dma_host.
// Signal names are seen from the DMA engine: _i flows into the engine, _o flows out of it.
interface bus_dma_reg_if #(
  parameter int AddressWidth = 32
) ();
  logic                    reg_req_i;
  logic                    reg_we_i;
  logic [3:0]              reg_be_i;
  logic [AddressWidth-1:0] reg_addr_i;
  logic [31:0]             reg_wdata_i;
  logic                    reg_rvalid_o;
  logic [31:0]             reg_rdata_o;
  logic                    reg_err_o;

  modport master (
    output reg_req_i, reg_we_i, reg_be_i, reg_addr_i, reg_wdata_i,
    input  reg_rvalid_o, reg_rdata_o, reg_err_o
  );

  modport slave (
    input  reg_req_i, reg_we_i, reg_be_i, reg_addr_i, reg_wdata_i,
    output reg_rvalid_o, reg_rdata_o, reg_err_o
  );
endinterface

interface bus_dma_host_bus_if #(
  parameter int AddressWidth = 32
) ();
  logic                    host_req_o;
  logic                    host_gnt_i;
  logic [AddressWidth-1:0] host_addr_o;
  logic                    host_we_o;
  logic [3:0]              host_be_o;
  logic [31:0]             host_wdata_o;
  logic                    host_rvalid_i;
  logic [31:0]             host_rdata_i;
  logic                    host_err_i;

  modport master (
    output host_req_o, host_addr_o, host_we_o, host_be_o, host_wdata_o,
    input  host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i
  );

  modport slave (
    input  host_req_o, host_addr_o, host_we_o, host_be_o, host_wdata_o,
    output host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i
  );
endinterface

// File: rtl/bus_dma_host.sv
// Word-copy DMA engine: software programs SRC/DST/LEN over the register port,
// then the engine reads SRC and writes DST one word at a time on the host bus.
module bus_dma_host #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int LenWidth     = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  bus_dma_reg_if.slave        regPort,
  bus_dma_host_bus_if.master  hostPort,
  output logic                dma_irq_o
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [AddressWidth-1:0] r_src;
  logic [AddressWidth-1:0] r_dst;
  logic [LenWidth-1:0]     r_len;
  logic                    r_irqEn;
  logic                    r_done;
  logic                    r_err;
  logic [AddressWidth-1:0] r_curSrc;
  logic [AddressWidth-1:0] r_curDst;
  logic [LenWidth-1:0]     r_remaining;
  logic [DataWidth-1:0]    r_buffer;
  logic                    r_regRvalid;
  logic [31:0]             r_regRdata;
  logic                    r_regErr;

  logic [2:0]  w_offset;
  logic        w_regWrite;
  logic        w_busy;
  logic        w_startAny;
  logic        w_startGo;
  logic [15:0] w_remField;
  logic [31:0] w_readData;
  logic        w_rdDone;
  logic        w_wrDone;
  logic        w_unused;

  assign w_offset   = regPort.reg_addr_i[4:2];
  assign w_regWrite = regPort.reg_req_i & regPort.reg_we_i;
  assign w_busy     = (r_state != IDLE);
  assign w_startAny = w_regWrite && (w_offset == 3'd3) && regPort.reg_wdata_i[0] && !w_busy;
  assign w_startGo  = w_startAny && (r_len != '0);
  assign w_remField = 16'(r_remaining);
  assign w_rdDone   = (r_state == RD_WAIT) && hostPort.host_rvalid_i;
  assign w_wrDone   = (r_state == WR_WAIT) && hostPort.host_rvalid_i;
  assign w_unused   = ^{regPort.reg_be_i, regPort.reg_addr_i[AddressWidth-1:5],
                        regPort.reg_addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_startGo) w_nextState = RD_REQ;
      RD_REQ:  if (hostPort.host_gnt_i) w_nextState = RD_WAIT;
      RD_WAIT: if (w_rdDone) w_nextState = hostPort.host_err_i ? IDLE : WR_REQ;
      WR_REQ:  if (hostPort.host_gnt_i) w_nextState = WR_WAIT;
      WR_WAIT: begin
        if (w_wrDone) begin
          w_nextState = (hostPort.host_err_i || r_remaining == LenWidth'(1)) ? IDLE : RD_REQ;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    hostPort.host_req_o   = 1'b0;
    hostPort.host_we_o    = 1'b0;
    hostPort.host_addr_o  = '0;
    hostPort.host_wdata_o = '0;
    case (r_state)
      RD_REQ: begin
        hostPort.host_req_o  = 1'b1;
        hostPort.host_addr_o = r_curSrc;
      end
      WR_REQ: begin
        hostPort.host_req_o   = 1'b1;
        hostPort.host_we_o    = 1'b1;
        hostPort.host_addr_o  = r_curDst;
        hostPort.host_wdata_o = r_buffer;
      end
      default: ;
    endcase
  end

  assign hostPort.host_be_o = 4'hF;

  always_comb begin
    w_readData = '0;
    case (w_offset)
      3'd0:    w_readData = 32'(r_src);
      3'd1:    w_readData = 32'(r_dst);
      3'd2:    w_readData = 32'(r_len);
      3'd3:    w_readData = {30'b0, r_irqEn, 1'b0};
      3'd4:    w_readData = {w_remField, 13'b0, r_err, r_done, w_busy};
      default: w_readData = '0;
    endcase
  end

  // Later assignments win, so an engine-side set of done/err beats a same-cycle W1C.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_irqEn     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_curSrc    <= '0;
      r_curDst    <= '0;
      r_remaining <= '0;
      r_buffer    <= '0;
      r_regRvalid <= 1'b0;
      r_regRdata  <= '0;
      r_regErr    <= 1'b0;
    end else begin
      r_regRvalid <= regPort.reg_req_i;
      r_regErr    <= regPort.reg_req_i && (w_offset > 3'd4);
      r_regRdata  <= (regPort.reg_req_i && !regPort.reg_we_i) ? w_readData : '0;

      if (w_regWrite) begin
        case (w_offset)
          3'd0: if (!w_busy) r_src <= AddressWidth'(regPort.reg_wdata_i) & ~AddressWidth'(3);
          3'd1: if (!w_busy) r_dst <= AddressWidth'(regPort.reg_wdata_i) & ~AddressWidth'(3);
          3'd2: if (!w_busy) r_len <= LenWidth'(regPort.reg_wdata_i);
          3'd3: r_irqEn <= regPort.reg_wdata_i[1];
          3'd4: begin
            if (regPort.reg_wdata_i[1]) r_done <= 1'b0;
            if (regPort.reg_wdata_i[2]) r_err  <= 1'b0;
          end
          default: ;
        endcase
      end

      if (w_startAny) begin
        r_curSrc    <= r_src;
        r_curDst    <= r_dst;
        r_remaining <= r_len;
        r_done      <= (r_len == '0);
        r_err       <= 1'b0;
      end

      if (w_rdDone) begin
        r_buffer <= hostPort.host_rdata_i;
        if (hostPort.host_err_i) begin
          r_err  <= 1'b1;
          r_done <= 1'b1;
        end
      end

      if (w_wrDone) begin
        r_curSrc    <= r_curSrc + AddressWidth'(4);
        r_curDst    <= r_curDst + AddressWidth'(4);
        r_remaining <= r_remaining - LenWidth'(1);
        if (hostPort.host_err_i || r_remaining == LenWidth'(1)) begin
          r_done <= 1'b1;
          if (hostPort.host_err_i) r_err <= 1'b1;
        end
      end
    end
  end

  assign regPort.reg_rvalid_o = r_regRvalid;
  assign regPort.reg_rdata_o  = r_regRdata;
  assign regPort.reg_err_o    = r_regErr;
  assign dma_irq_o            = r_done & r_irqEn;

endmodule
